// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: FSM state type and active-low 7-segment constants for bin2bcd_seq.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit order g..a, active low; codes 10-15 are not BCD and stay dark.
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

endpackage

// File: rtl/bcd7seg.sv
// bcd7seg: combinational BCD digit to active-low 7-segment pattern (g..a).
module bcd7seg
    import bin2bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TBL[i_bcd];

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD with saturating overflow and 7-segment outputs.
// Define BIN2BCD_LZB_EN to blank leading zero digits on hex (digit 0 always shown).
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic             overflow,
    output logic [7*D-1:0]   hex
);

    localparam int CW = $clog2(W + 1);

`ifdef BIN2BCD_LZB_EN
    localparam logic [7*D-1:0] HEX_RST = ({D{SEG_BLANK}} << 7) | (7*D)'(SEG_TBL[0]);
`else
    localparam logic [7*D-1:0] HEX_RST = {D{SEG_TBL[0]}};
`endif

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_sr;
    logic [4*D-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic [4*D-1:0]   r_bcd;
    logic             r_overflow;
    logic [7*D-1:0]   r_hex;

    logic [4*D-1:0]   w_adj, w_acc_nxt, w_bcd_nxt;
    logic             w_ovf_nxt, w_last;
    logic [7*D-1:0]   w_seg, w_hex_nxt;

    always_comb begin
        w_adj = r_acc;
        for (int k = 0; k < D; k++)
            w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ? r_acc[4*k +: 4] + 4'd3 : r_acc[4*k +: 4];
    end

    // The top bit of the adjusted accumulator is what falls off the last digit.
    assign w_acc_nxt = {w_adj[4*D-2:0], r_sr[W-1]};
    assign w_ovf_nxt = r_ovf | w_adj[4*D-1];
    assign w_bcd_nxt = w_ovf_nxt ? {D{4'h9}} : w_acc_nxt;
    assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(1));

    for (genvar g = 0; g < D; g++) begin : g_seg
        bcd7seg u_seg (
            .i_bcd (w_bcd_nxt[4*g +: 4]),
            .o_seg (w_seg[7*g +: 7])
        );
    end

`ifdef BIN2BCD_LZB_EN
    logic w_lead;

    always_comb begin
        w_hex_nxt = w_seg;
        w_lead    = 1'b1;
        for (int k = D - 1; k > 0; k--) begin
            w_lead = w_lead & (w_bcd_nxt[4*k +: 4] == 4'd0);
            if (w_lead)
                w_hex_nxt[7*k +: 7] = SEG_BLANK;
        end
    end
`else
    assign w_hex_nxt = w_seg;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = start ? SHIFT : IDLE;
            SHIFT:   w_state_nxt = (r_cnt == CW'(1)) ? DONE : SHIFT;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_hex      <= HEX_RST;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && start) begin
                r_sr  <= bin;
                r_acc <= '0;
                r_cnt <= CW'(W);
                r_ovf <= 1'b0;
            end else if (r_state == SHIFT) begin
                r_sr  <= {r_sr[W-2:0], 1'b0};
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - 1'b1;
                r_ovf <= w_ovf_nxt;
            end
            // Results land on the edge into DONE so they are valid alongside done.
            if (w_last) begin
                r_bcd      <= w_bcd_nxt;
                r_overflow <= w_ovf_nxt;
                r_hex      <= w_hex_nxt;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign bcd      = r_bcd;
    assign overflow = r_overflow;
    assign hex      = r_hex;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq (W=8 with D=3, plus a D=2 instance).
// Expected hex values follow BIN2BCD_LZB_EN when defined.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start2 = 1'b0;
    logic [7:0]  bin = '0, bin2 = '0;
    logic        busy, done, overflow, busy2, done2, overflow2;
    logic [11:0] bcd;
    logic [7:0]  bcd2;
    logic [20:0] hex;
    logic [13:0] hex2;

    int nvec = 0;
    int nerr = 0;

    bin2bcd_seq #(.W(8), .D(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .busy(busy),
        .done(done), .bcd(bcd), .overflow(overflow), .hex(hex)
    );

    bin2bcd_seq #(.W(8), .D(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2), .busy(busy2),
        .done(done2), .bcd(bcd2), .overflow(overflow2), .hex(hex2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in cycle 0, then watch cycles 1..12 for busy/done timing and output hold.
    task automatic run(input logic [7:0] b, input logic use2, input logic [7:0] b2);
        logic [11:0] held;
        held   = bcd;
        bin    = b;
        start  = 1'b1;
        bin2   = b2;
        start2 = use2;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("busy@%0d", c), 32'(busy), 32'(c <= 9));
            chk($sformatf("done@%0d", c), 32'(done), 32'(c == 9));
            if (c <= 8)
                chk($sformatf("hold@%0d", c), 32'(bcd), 32'(held));
            if (use2)
                chk($sformatf("done2@%0d", c), 32'(done2), 32'(c == 9));
            tick();
        end
    endtask

    initial begin
        logic [20:0] hz, h37, h7;
        int ndone;
`ifdef BIN2BCD_LZB_EN
        hz  = {7'h7F, 7'h7F, 7'h40};
        h37 = {7'h7F, 7'h30, 7'h78};
        h7  = {7'h7F, 7'h7F, 7'h78};
`else
        hz  = {7'h40, 7'h40, 7'h40};
        h37 = {7'h40, 7'h30, 7'h78};
        h7  = {7'h40, 7'h40, 7'h78};
`endif
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_hex", 32'(hex), 32'(hz));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run(8'd0, 1'b0, 8'd0);
        chk("z_bcd", 32'(bcd), 32'h000);
        chk("z_ovf", 32'(overflow), 0);
        chk("z_hex0", 32'(hex[6:0]), 32'h40);
        chk("z_hex", 32'(hex), 32'(hz));

        run(8'd255, 1'b1, 8'd100);
        chk("ff_bcd", 32'(bcd), 32'h255);
        chk("ff_ovf", 32'(overflow), 0);
        chk("ff_hex", 32'(hex), 32'({7'h24, 7'h12, 7'h12}));
        chk("d2_bcd", 32'(bcd2), 32'h99);
        chk("d2_ovf", 32'(overflow2), 1);
        chk("d2_hex", 32'(hex2), 32'({7'h10, 7'h10}));

        bin   = 8'd37;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) begin
                bin   = 8'h11;
                start = 1'b1;
            end
            if (c == 4)
                start = 1'b0;
            if (c == 5)
                chk("mid_hold", 32'(bcd), 32'h255);
            if (done)
                ndone++;
            tick();
        end
        chk("ign_bcd", 32'(bcd), 32'h037);
        chk("ign_ndone", 32'(ndone), 1);
        chk("ign_hex", 32'(hex), 32'(h37));

        run(8'd7, 1'b0, 8'd0);
        chk("s7_bcd", 32'(bcd), 32'h007);
        chk("s7_hex", 32'(hex), 32'(h7));

        bin   = 8'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_bcd", 32'(bcd), 32'h000);
        chk("ar_done", 32'(done), 0);
        chk("ar_hex", 32'(hex), 32'(hz));
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 14; c++) begin
            if (done || busy)
                ndone++;
            tick();
        end
        chk("ar_nodone", 32'(ndone), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter W, default 8, binary input width (W >= 2).
REQ-002 Parameter D, default 3, number of BCD digits produced (D >= 1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a conversion of bin; sampled only in IDLE.
REQ-006 bin  input  W  unsigned binary value to convert.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when bcd/hex/overflow update.
REQ-009 bcd  output  4*D  packed BCD result, digit 0 in bits [3:0].
REQ-010 overflow  output  1  last result exceeded 10^D-1.
REQ-011 hex  output  7*D  active-low 7-segment patterns, digit k in bits [7k+6:7k], bit order g..a.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 In IDLE with start=1, the block SHALL capture bin into a W-bit shift register, clear the 4*D-bit BCD accumulator and the overflow flag, load a bit counter with W, and enter SHIFT.
REQ-014 Each SHIFT cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one, decrement the counter, and OR any bit shifted out of the top digit into overflow.
REQ-015 After W SHIFT cycles the FSM SHALL enter DONE; in DONE it SHALL register bcd, hex and overflow, assert done for exactly that cycle, and return to IDLE.
REQ-016 With start sampled in cycle 0, done SHALL be high in cycle W+1; busy SHALL be high in cycles 1 through W+1.
REQ-017 start SHALL be ignored while busy; a new start is accepted in the cycle after done at the earliest.
REQ-018 bcd, hex and overflow SHALL hold their last registered values between done pulses and SHALL NOT change during a conversion.
REQ-019 On overflow, bcd SHALL saturate to all digits 9 and hex SHALL show all 9s.
REQ-020 Segment encoding (active-low, g..a): 0=0x40 1=0x79 2=0x24 3=0x30 4=0x19 5=0x12 6=0x02 7=0x78 8=0x00 9=0x10.
REQ-021 Arithmetic SHALL be unsigned; no sign handling.

Reset
REQ-022 On rst_n low, asynchronously: state IDLE, busy=0, done=0, bcd=0, overflow=0, counter=0, and every hex digit = 0x40 (subject to REQ-024).
REQ-023 Reset asserted mid-conversion SHALL abort the conversion without a done pulse; the next conversion requires a new start.

Configuration
REQ-024 Macro BIN2BCD_LZB_EN defined: leading-zero blanking; every hex digit above the most significant non-zero digit SHALL be 0x7F (blank), and digit 0 SHALL always be displayed; applies after reset and after every done.
REQ-025 Macro BIN2BCD_LZB_EN undefined: all D digits SHALL always be displayed, including leading zeros.

Structure
REQ-026 Package bin2bcd_pkg SHALL hold the FSM state typedef, the 16-entry segment constant table (codes 10-15 map to 0x7F), and the blank constant 0x7F.
REQ-027 One sub-module, bcd7seg (4-bit BCD in, 7-bit active-low segments out, combinational), SHALL be instantiated D times via generate.

Verification (W=8, D=3 unless stated)
REQ-028 bin=0, start pulse in cycle 0 -> done in cycle 9 only, bcd=0x000, overflow=0, hex[6:0]=0x40.
REQ-029 bin=255 -> bcd=0x255, hex={0x24,0x12,0x12}, overflow=0, busy high in cycles 1-9.
REQ-030 D=2, bin=100 -> overflow=1, bcd=0x99, both hex digits 0x10.
REQ-031 bin=37 started, then start with bin=0x11 in cycle 3 -> second start ignored, bcd=0x037, only one done pulse.
REQ-032 rst_n low in cycle 4 of a conversion -> busy=0, bcd=0x000 immediately without waiting for clk, no done pulse afterwards.
REQ-033 bin=7 -> with BIN2BCD_LZB_EN, hex digits 2 and 1 = 0x7F and digit 0 = 0x78; without it, digits 2 and 1 = 0x40.
